// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the RAM burst access controller.
// Holds the FSM state enum plus width and read-latency defaults.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/ram_rd_valid_pipe.sv
// Read-valid delay line: DEPTH-deep shift register of 1-bit flags.
// Ports: clock, rstn (async low), in_i (flag pushed), flags_o (bit DEPTH-1 oldest).
module ram_rd_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             in_i,
  output logic [DEPTH-1:0] flags_o
);

  logic [DEPTH-1:0] flags_q;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      flags_q <= '0;
    end else begin
      flags_q <= (flags_q << 1) | DEPTH'(in_i);
    end
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/ram_access_ctrl.sv
// Burst controller driving a single-port RAM: one request -> len+1 beats.
// Ports: req_* handshake, wr_data stream in, rd_data/rd_valid out, ram_* port.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_W_DEF,
  parameter int DATA_WIDTH   = DATA_W_DEF,
  parameter int LEN_WIDTH    = LEN_W_DEF,
  parameter int READ_LATENCY = RD_LAT_DEF
) (
  input  logic                  clock,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_data_valid,
  output logic                  wr_data_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam int DEPTH = READ_LATENCY + 1;
  // Pipe pattern when only the final read is still in flight.
  localparam logic [DEPTH-1:0] LAST_ONLY = DEPTH'(1) << (DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;
  logic                  ram_wren_q, ram_wren_d;
  logic                  push;
  logic [DEPTH-1:0]      flags;
  logic                  last_beat;

  assign last_beat = (cnt_q == len_q);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      ram_wren_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
      ram_wren_q    <= ram_wren_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    ram_wren_d    = 1'b0;
    push          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cur_d   = req_addr;
          len_d   = req_len;
          cnt_d   = '0;
          state_d = req_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (wr_data_valid) begin
          ram_wren_d    = 1'b1;
          ram_address_d = cur_q;
          ram_data_in_d = wr_data;
          cur_d         = cur_q + ADDR_WIDTH'(1);
          cnt_d         = cnt_q + LEN_WIDTH'(1);
          if (last_beat) state_d = S_DONE;
        end
      end
      S_READ: begin
        ram_address_d = cur_q;
        push          = 1'b1;
        cur_d         = cur_q + ADDR_WIDTH'(1);
        cnt_d         = cnt_q + LEN_WIDTH'(1);
        if (last_beat) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (flags == LAST_ONLY) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  ram_rd_valid_pipe #(
    .DEPTH(DEPTH)
  ) u_pipe (
    .clock  (clock),
    .rstn   (rstn),
    .in_i   (push),
    .flags_o(flags)
  );

  assign req_ready     = (state_q == S_IDLE);
  assign wr_data_ready = (state_q == S_WRITE);
  assign done          = (state_q == S_DONE);
  assign rd_valid      = flags[DEPTH-1];
  assign rd_data       = ram_data_out;
  assign ram_address   = ram_address_q;
  assign ram_data_in   = ram_data_in_q;
  assign ram_wren      = ram_wren_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Testbench for ram_access_ctrl with a behavioural 1-cycle RAM model.
// Write/read beats are scoreboarded through queues.
module tb_ram_access_ctrl;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int LW = 4;

  logic          clock = 1'b0;
  logic          rstn = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_data_valid = 1'b0;
  logic          wr_data_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic          ram_wren;
  logic [DW-1:0] ram_data_out;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  int tests = 0;
  int fails = 0;

  logic [AW+DW-1:0] wq [$];
  logic [DW-1:0]    rq [$];
  logic [AW+DW-1:0] we;
  logic [DW-1:0]    re;

  ram_access_ctrl dut (
    .clock        (clock),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .wr_data      (wr_data),
    .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .done         (done),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_wren     (ram_wren),
    .ram_data_out (ram_data_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
  end

  always @(negedge clock) begin
    if (ram_wren === 1'b1) begin
      tests++;
      if (wq.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: addr=%h data=%h, required no write",
                 ram_address, ram_data_in);
      end else begin
        we = wq.pop_front();
        if ({ram_address, ram_data_in} !== we) begin
          fails++;
          $display("FAIL wr_beat: addr/data=%h/%h, required %h/%h",
                   ram_address, ram_data_in, we[AW+DW-1:DW], we[DW-1:0]);
        end
      end
    end
    if (rd_valid === 1'b1) begin
      tests++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: data=%h, required no rd_valid", rd_data);
      end else begin
        re = rq.pop_front();
        if (rd_data !== re) begin
          fails++;
          $display("FAIL rd_beat: data=%h, required %h", rd_data, re);
        end
      end
    end
  end

  task automatic issue_req(input logic w, input logic [AW-1:0] a,
                           input logic [LW-1:0] l, output int waited);
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL req_ready_timeout: req_ready=%b, required 1", req_ready);
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle_check(input string nm);
    @(negedge clock);
    tests++;
    if ({req_ready, ram_wren, done, rd_valid} !== 4'b1000) begin
      fails++;
      $display("FAIL %s_idle: rdy/wren/done/rdv=%b%b%b%b, required 1000",
               nm, req_ready, ram_wren, done, rd_valid);
    end
  endtask

  task automatic write_burst(input string nm, input logic [AW-1:0] a,
                             input int len, input logic [31:0] stall,
                             input logic [DW-1:0] d0, output int waited);
    int beat, k, nwr;
    logic acc_prev, exp_rdy, exp_done;
    bit seen, stl;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    beat = 0; k = 0; nwr = 0; acc_prev = 1'b0; seen = 1'b0;
    issue_req(1'b1, a, LW'(len), waited);
    while (!seen && k < 40) begin
      stl = (k < 32) ? stall[k[4:0]] : 1'b0;
      if (beat <= len && !stl) begin
        ea = a + AW'(beat);
        ed = d0 + DW'(beat);
        wr_data = ed;
        wr_data_valid = 1'b1;
        wq.push_back({ea, ed});
        shadow[ea] = ed;
      end
      @(negedge clock);
      exp_rdy  = (beat <= len);
      exp_done = (beat == len + 1);
      tests++;
      if (ram_wren !== acc_prev) begin
        fails++;
        $display("FAIL %s_wren c%0d: wren=%b, required %b", nm, k, ram_wren, acc_prev);
      end
      tests++;
      if (wr_data_ready !== exp_rdy) begin
        fails++;
        $display("FAIL %s_wrdy c%0d: wr_data_ready=%b, required %b",
                 nm, k, wr_data_ready, exp_rdy);
      end
      tests++;
      if (done !== exp_done) begin
        fails++;
        $display("FAIL %s_done c%0d: done=%b, required %b", nm, k, done, exp_done);
      end
      tests++;
      if (req_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s_busy c%0d: req_ready=%b, required 0", nm, k, req_ready);
      end
      if (done === 1'b1) seen = 1'b1;
      if (ram_wren === 1'b1) nwr++;
      acc_prev = wr_data_valid;
      if (wr_data_valid) beat++;
      @(posedge clock);
      #1;
      wr_data_valid = 1'b0;
      k++;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_timeout: done not seen in 40 cycles, required pulse", nm);
    end
    tests++;
    if (nwr != len + 1) begin
      fails++;
      $display("FAIL %s_count: writes=%0d, required %0d", nm, nwr, len + 1);
    end
    idle_check(nm);
  endtask

  task automatic read_burst(input string nm, input logic [AW-1:0] a,
                            input int len, output int waited);
    logic exp_v, exp_d;
    logic [AW-1:0] ea;
    issue_req(1'b0, a, LW'(len), waited);
    for (int k = 0; k <= len + 3; k++) begin
      if (k <= len) rq.push_back(shadow[a + AW'(k)]);
      @(negedge clock);
      exp_v = (k >= 2 && k <= len + 2);
      exp_d = (k == len + 3);
      tests++;
      if (rd_valid !== exp_v) begin
        fails++;
        $display("FAIL %s_rdv c%0d: rd_valid=%b, required %b", nm, k, rd_valid, exp_v);
      end
      tests++;
      if (done !== exp_d) begin
        fails++;
        $display("FAIL %s_done c%0d: done=%b, required %b", nm, k, done, exp_d);
      end
      tests++;
      if ({ram_wren, req_ready} !== 2'b00) begin
        fails++;
        $display("FAIL %s_busy c%0d: wren/req_ready=%b%b, required 00",
                 nm, k, ram_wren, req_ready);
      end
      if (k >= 1 && k <= len + 1) begin
        ea = a + AW'(k - 1);
        tests++;
        if (ram_address !== ea) begin
          fails++;
          $display("FAIL %s_addr c%0d: ram_address=%h, required %h",
                   nm, k, ram_address, ea);
        end
      end
      @(posedge clock);
      #1;
    end
    idle_check(nm);
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    #2;
    tests++;
    if ({ram_address, ram_data_in, ram_wren, rd_valid, done, wr_data_ready} !== '0) begin
      fails++;
      $display("FAIL reset_outs: addr=%h din=%h wren=%b rdv=%b done=%b wrdy=%b, required 0",
               ram_address, ram_data_in, ram_wren, rd_valid, done, wr_data_ready);
    end
    @(negedge clock);
    @(negedge clock);
    rstn = 1'b1;
    @(negedge clock);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_reset_mid_burst();
    int w;
    issue_req(1'b1, 12'h010, 4'd3, w);
    wr_data = 8'h11;
    wr_data_valid = 1'b1;
    wq.push_back({12'h010, 8'h11});
    @(posedge clock);
    #1;
    wr_data = 8'h12;
    @(negedge clock);
    #1 rstn = 1'b0;
    #1;
    tests++;
    if ({ram_address, ram_data_in, ram_wren, rd_valid, done, wr_data_ready} !== '0) begin
      fails++;
      $display("FAIL midrst_outs: addr=%h din=%h wren=%b rdv=%b done=%b wrdy=%b, required 0",
               ram_address, ram_data_in, ram_wren, rd_valid, done, wr_data_ready);
    end
    @(negedge clock);
    @(negedge clock);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'h13 + 8'(i);
      @(negedge clock);
      tests++;
      if ({req_ready, ram_wren, wr_data_ready} !== 3'b100) begin
        fails++;
        $display("FAIL midrst_after c%0d: rdy/wren/wrdy=%b%b%b, required 100",
                 i, req_ready, ram_wren, wr_data_ready);
      end
    end
    wr_data_valid = 1'b0;
  endtask

  task automatic test_write_stall();
    int w;
    write_burst("wstall", 12'h100, 3, 32'h0000_000C, 8'hB0, w);
  endtask

  task automatic test_write_burst();
    int w;
    write_burst("wburst", 12'h100, 3, 32'h0, 8'hA0, w);
  endtask

  task automatic test_read_burst();
    int w;
    read_burst("rburst", 12'h100, 3, w);
  endtask

  task automatic test_wrap();
    int w;
    write_burst("wwrap", 12'hFFE, 3, 32'h0, 8'hC0, w);
    read_burst("rwrap", 12'hFFE, 3, w);
  endtask

  task automatic test_back_to_back();
    int w;
    write_burst("b2b_w", 12'h005, 0, 32'h0, 8'h5A, w);
    read_burst("b2b_r", 12'h005, 0, w);
    tests++;
    if (w != 0) begin
      fails++;
      $display("FAIL b2b_gap: waited %0d cycles for req_ready, required 0", w);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_write_stall();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_back_to_back();
    repeat (3) @(negedge clock);
    tests++;
    if (wq.size() != 0 || rq.size() != 0) begin
      fails++;
      $display("FAIL sb_empty: pending wr=%0d rd=%0d, required 0/0",
               wq.size(), rq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
